tcm_arbiter: RTL and testbench

Single-port TCM arbiter placed between the core-side bus requesters (instruction fetch, store-buffer read, store-buffer write) and one shared TCM access port. It serialises the three requesters onto the port with fixed priority and a fetch anti-starvation counter. It runs a request/ack handshake on both sides and returns registered read data and one-cycle ack pulses to the winning requester.

---
 rtl/tcm_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_tcm_arbiter.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcm_arbiter.sv
// ---------------------------------------------------------------------------
// TcmArbiter
// Serialises three core-side requesters onto one shared single-port TCM:
// instruction fetch, store-buffer read (load) and store-buffer write.
// Fixed priority is write > read > fetch. A starvation counter lets a
// waiting fetch win once STARVE_LIMIT store-buffer grants in a row have gone
// past it. Every output is registered.
//
// Ports
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   fetch_arb_addr_i/req_i            fetch request (payload held until ack)
//   arb_fetch_data_o/ack_o            fetch read data and completion pulse
//   stbuf_arb_read_addr_i/size_i/req_i     load request
//   stbuf_arb_write_addr_i/size_i/req_i    store request
//   stbuf_arb_data_i                  store data
//   arb_stbuf_data_o                  load data (low REG_DATA_WIDTH bits)
//   arb_stbuf_read_ack_o/write_ack_o  load/store completion pulses
//   arb_tcm_addr_o/size_o/data_o      granted access towards the TCM
//   arb_tcm_rd_o/wr_o                 TCM read/write strobes (one-hot or 0)
//   tcm_arb_data_i/ack_i              TCM read data and completion
// ---------------------------------------------------------------------------
module tcm_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int SIZE_WIDTH     = 2,
  parameter int REG_DATA_WIDTH = 32,
  parameter int BUS_DATA_WIDTH = 128,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [ADDR_WIDTH-1:0]     fetch_arb_addr_i,
  input  logic                      fetch_arb_req_i,
  output logic [BUS_DATA_WIDTH-1:0] arb_fetch_data_o,
  output logic                      arb_fetch_ack_o,
  input  logic [ADDR_WIDTH-1:0]     stbuf_arb_read_addr_i,
  input  logic [SIZE_WIDTH-1:0]     stbuf_arb_read_size_i,
  input  logic                      stbuf_arb_read_req_i,
  input  logic [ADDR_WIDTH-1:0]     stbuf_arb_write_addr_i,
  input  logic [SIZE_WIDTH-1:0]     stbuf_arb_write_size_i,
  input  logic [REG_DATA_WIDTH-1:0] stbuf_arb_data_i,
  input  logic                      stbuf_arb_write_req_i,
  output logic [REG_DATA_WIDTH-1:0] arb_stbuf_data_o,
  output logic                      arb_stbuf_read_ack_o,
  output logic                      arb_stbuf_write_ack_o,
  output logic [ADDR_WIDTH-1:0]     arb_tcm_addr_o,
  output logic [SIZE_WIDTH-1:0]     arb_tcm_size_o,
  output logic [REG_DATA_WIDTH-1:0] arb_tcm_data_o,
  output logic                      arb_tcm_rd_o,
  output logic                      arb_tcm_wr_o,
  input  logic [BUS_DATA_WIDTH-1:0] tcm_arb_data_i,
  input  logic                      tcm_arb_ack_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] OWN_FETCH = 2'd0;
  localparam logic [1:0] OWN_READ  = 2'd1;
  localparam logic [1:0] OWN_WRITE = 2'd2;

  localparam int              CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [1:0]                state_q, state_d;
  logic [1:0]                owner_q, owner_d;
  logic [CNT_W-1:0]          starve_q, starve_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [SIZE_WIDTH-1:0]     size_q, size_d;
  logic [REG_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                      rd_q, rd_d;
  logic                      wr_q, wr_d;
  logic [BUS_DATA_WIDTH-1:0] fetch_data_q, fetch_data_d;
  logic [REG_DATA_WIDTH-1:0] stbuf_data_q, stbuf_data_d;
  logic                      fetch_ack_q, fetch_ack_d;
  logic                      read_ack_q, read_ack_d;
  logic                      write_ack_q, write_ack_d;
  logic                      any_req;
  logic                      fetch_wins;

  // Fetch normally has lowest priority; it jumps the queue only once the
  // store buffer has taken STARVE_LIMIT consecutive grants while it waited.
  assign any_req    = fetch_arb_req_i | stbuf_arb_read_req_i | stbuf_arb_write_req_i;
  assign fetch_wins = fetch_arb_req_i &
                      ((starve_q == STARVE_MAX) |
                       ~(stbuf_arb_read_req_i | stbuf_arb_write_req_i));

  // Next-state logic. The payload is copied into the output registers at
  // grant time, so later changes on the requester side have no effect.
  // Ack pulses default low and are only raised on the BUSY->RESP step,
  // which makes them exactly one cycle wide.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_d     = starve_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    fetch_data_d = fetch_data_q;
    stbuf_data_d = stbuf_data_q;
    fetch_ack_d  = 1'b0;
    read_ack_d   = 1'b0;
    write_ack_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_BUSY;
          if (fetch_wins) begin
            owner_d  = OWN_FETCH;
            addr_d   = fetch_arb_addr_i;
            size_d   = '0;
            wdata_d  = '0;
            rd_d     = 1'b1;
            wr_d     = 1'b0;
            starve_d = '0;
          end else begin
            if (stbuf_arb_write_req_i) begin
              owner_d = OWN_WRITE;
              addr_d  = stbuf_arb_write_addr_i;
              size_d  = stbuf_arb_write_size_i;
              wdata_d = stbuf_arb_data_i;
              rd_d    = 1'b0;
              wr_d    = 1'b1;
            end else begin
              owner_d = OWN_READ;
              addr_d  = stbuf_arb_read_addr_i;
              size_d  = stbuf_arb_read_size_i;
              wdata_d = '0;
              rd_d    = 1'b1;
              wr_d    = 1'b0;
            end
            // A store-buffer grant only counts against fetch if fetch is
            // actually waiting; otherwise the streak is broken.
            if (!fetch_arb_req_i) begin
              starve_d = '0;
            end else if (starve_q != STARVE_MAX) begin
              starve_d = starve_q + CNT_W'(1);
            end
          end
        end
      end

      ST_BUSY: begin
        if (tcm_arb_ack_i) begin
          state_d = ST_RESP;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          case (owner_q)
            OWN_FETCH: begin
              fetch_data_d = tcm_arb_data_i;
              fetch_ack_d  = 1'b1;
            end
            OWN_READ: begin
              stbuf_data_d = tcm_arb_data_i[REG_DATA_WIDTH-1:0];
              read_ack_d   = 1'b1;
            end
            default: begin
              write_ack_d = 1'b1;
            end
          endcase
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers. Reset abandons any in-flight access
  // without producing an ack.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_FETCH;
      starve_q     <= '0;
      addr_q       <= '0;
      size_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      fetch_data_q <= '0;
      stbuf_data_q <= '0;
      fetch_ack_q  <= 1'b0;
      read_ack_q   <= 1'b0;
      write_ack_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_q     <= starve_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      fetch_data_q <= fetch_data_d;
      stbuf_data_q <= stbuf_data_d;
      fetch_ack_q  <= fetch_ack_d;
      read_ack_q   <= read_ack_d;
      write_ack_q  <= write_ack_d;
    end
  end

  assign arb_tcm_addr_o        = addr_q;
  assign arb_tcm_size_o        = size_q;
  assign arb_tcm_data_o        = wdata_q;
  assign arb_tcm_rd_o          = rd_q;
  assign arb_tcm_wr_o          = wr_q;
  assign arb_fetch_data_o      = fetch_data_q;
  assign arb_fetch_ack_o       = fetch_ack_q;
  assign arb_stbuf_data_o      = stbuf_data_q;
  assign arb_stbuf_read_ack_o  = read_ack_q;
  assign arb_stbuf_write_ack_o = write_ack_q;

endmodule

// File: tb/tb_tcm_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tcm_arbiter
// Self-checking bench for tcm_arbiter. A behavioural TCM with programmable
// wait states and a small requester model run once per cycle on the falling
// edge. Expected grants and responses are queued when stimulus is driven and
// compared as the arbiter produces them.
// ---------------------------------------------------------------------------
module tb_tcm_arbiter;

  localparam int AW = 32;
  localparam int SW = 2;
  localparam int RW = 32;
  localparam int BW = 128;
  localparam int SL = 4;

  localparam logic [2:0] K_FETCH = 3'b100;
  localparam logic [2:0] K_READ  = 3'b010;
  localparam logic [2:0] K_WRITE = 3'b001;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] read_addr = '0;
  logic [SW-1:0] read_size = '0;
  logic          read_req = 1'b0;
  logic [AW-1:0] write_addr = '0;
  logic [SW-1:0] write_size = '0;
  logic [RW-1:0] write_data = '0;
  logic          write_req = 1'b0;
  logic [BW-1:0] tcm_rdata = '0;
  logic          tcm_ack = 1'b0;

  logic [BW-1:0] arb_fetch_data;
  logic          arb_fetch_ack;
  logic [RW-1:0] arb_stbuf_data;
  logic          arb_stbuf_read_ack;
  logic          arb_stbuf_write_ack;
  logic [AW-1:0] arb_tcm_addr;
  logic [SW-1:0] arb_tcm_size;
  logic [RW-1:0] arb_tcm_data;
  logic          arb_tcm_rd;
  logic          arb_tcm_wr;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [SW-1:0] size;
    logic [RW-1:0] data;
  } grant_t;

  typedef struct {
    logic [2:0]    ackVec;
    logic [BW-1:0] fetchData;
    logic [RW-1:0] stbufData;
  } resp_t;

  typedef struct {
    logic [2:0]    kind;
    logic [AW-1:0] addr;
    logic [SW-1:0] size;
    logic [RW-1:0] wdata;
    int            latency;
    logic          expRd;
    logic          expWr;
    logic [SW-1:0] expSize;
    logic [RW-1:0] expData;
    logic [BW-1:0] expResp;
  } vector_t;

  grant_t        grantQ[$];
  resp_t         respQ[$];
  grant_t        heldGrant;
  logic          prevStrobe = 1'b0;
  logic [BW-1:0] expFetchData = '0;
  logic [RW-1:0] expStbufData = '0;
  int            tcmLatency = 0;
  int            waitCnt = 0;
  logic          forceIdleAck = 1'b0;
  int            writeRepeat = 0;
  int            writeIdx = 0;
  int            fetchRepeat = 0;
  int            checks = 0;
  int            failures = 0;
  vector_t       vectors[6];

  // Device under test with every port wired to the bench.
  tcm_arbiter #(
    .ADDR_WIDTH     (AW),
    .SIZE_WIDTH     (SW),
    .REG_DATA_WIDTH (RW),
    .BUS_DATA_WIDTH (BW),
    .STARVE_LIMIT   (SL)
  ) dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_n),
    .fetch_arb_addr_i       (fetch_addr),
    .fetch_arb_req_i        (fetch_req),
    .arb_fetch_data_o       (arb_fetch_data),
    .arb_fetch_ack_o        (arb_fetch_ack),
    .stbuf_arb_read_addr_i  (read_addr),
    .stbuf_arb_read_size_i  (read_size),
    .stbuf_arb_read_req_i   (read_req),
    .stbuf_arb_write_addr_i (write_addr),
    .stbuf_arb_write_size_i (write_size),
    .stbuf_arb_data_i       (write_data),
    .stbuf_arb_write_req_i  (write_req),
    .arb_stbuf_data_o       (arb_stbuf_data),
    .arb_stbuf_read_ack_o   (arb_stbuf_read_ack),
    .arb_stbuf_write_ack_o  (arb_stbuf_write_ack),
    .arb_tcm_addr_o         (arb_tcm_addr),
    .arb_tcm_size_o         (arb_tcm_size),
    .arb_tcm_data_o         (arb_tcm_data),
    .arb_tcm_rd_o           (arb_tcm_rd),
    .arb_tcm_wr_o           (arb_tcm_wr),
    .tcm_arb_data_i         (tcm_rdata),
    .tcm_arb_ack_i          (tcm_ack)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Hard stop in case something in the bench itself wedges.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Contents of the behavioural TCM, keyed by address.
  function automatic logic [BW-1:0] memModel(input logic [AW-1:0] a);
    case (a)
      32'h10:  memModel = 128'habbccdde_12574985_1000203f_abcdef12;
      32'h20:  memModel = 128'h01234567_89abcdef_0f0f0f0f_fedd1698;
      default: memModel = {a ^ 32'h5a5a5a5a, ~a, a + 32'h1, a};
    endcase
  endfunction

  // Grant the arbiter should present for a request of a given kind.
  function automatic grant_t modelGrant(input logic [2:0] kind, input logic [AW-1:0] a,
                                        input logic [SW-1:0] s, input logic [RW-1:0] d);
    grant_t g;
    g.rd   = (kind != K_WRITE);
    g.wr   = (kind == K_WRITE);
    g.addr = a;
    g.size = (kind == K_FETCH) ? '0 : s;
    g.data = (kind == K_WRITE) ? d : '0;
    return g;
  endfunction

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [BW-1:0] actual,
                             input logic [BW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Queue the grant and the response for one access, tracking what both
  // data outputs must show when its ack arrives.
  task automatic pushExpected(input logic [2:0] kind, input grant_t g, input logic [BW-1:0] resp);
    resp_t r;
    grantQ.push_back(g);
    if (kind == K_FETCH) expFetchData = resp;
    else if (kind == K_READ) expStbufData = resp[RW-1:0];
    r.ackVec    = kind;
    r.fetchData = expFetchData;
    r.stbufData = expStbufData;
    respQ.push_back(r);
  endtask

  // Monitor: ack timing against the TCM ack seen at the last edge, new grants
  // against the scoreboard, strobe payload stability while busy, and each
  // requester ack against the queued response.
  task automatic observe();
    logic   strobe;
    logic   sampledAck;
    logic [2:0] ackVec;
    grant_t g;
    resp_t  r;
    strobe     = arb_tcm_rd | arb_tcm_wr;
    ackVec     = {arb_fetch_ack, arb_stbuf_read_ack, arb_stbuf_write_ack};
    sampledAck = prevStrobe & tcm_ack;
    if (strobe) checkOutput("oneStrobe", arb_tcm_rd & arb_tcm_wr, 0);
    if (sampledAck || ackVec != 3'b000) checkOutput("ackTiming", |ackVec, sampledAck);
    if (ackVec != 3'b000) begin
      if (respQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpectedAck: got ack %b, expected none", ackVec);
      end else begin
        r = respQ.pop_front();
        checkOutput("ackOwner", ackVec, r.ackVec);
        checkOutput("fetchData", arb_fetch_data, r.fetchData);
        checkOutput("stbufData", arb_stbuf_data, r.stbufData);
      end
    end
    if (strobe && !prevStrobe) begin
      if (grantQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpectedGrant: got rd=%b wr=%b addr=%h, expected none",
                 arb_tcm_rd, arb_tcm_wr, arb_tcm_addr);
      end else begin
        g = grantQ.pop_front();
        heldGrant = g;
        checkOutput("grantRd", arb_tcm_rd, g.rd);
        checkOutput("grantWr", arb_tcm_wr, g.wr);
        checkOutput("grantAddr", arb_tcm_addr, g.addr);
        checkOutput("grantSize", arb_tcm_size, g.size);
        checkOutput("grantData", arb_tcm_data, g.data);
      end
    end else if (strobe && prevStrobe) begin
      checkOutput("stableRd", arb_tcm_rd, heldGrant.rd);
      checkOutput("stableWr", arb_tcm_wr, heldGrant.wr);
      checkOutput("stableAddr", arb_tcm_addr, heldGrant.addr);
      checkOutput("stableSize", arb_tcm_size, heldGrant.size);
      checkOutput("stableData", arb_tcm_data, heldGrant.data);
    end
    prevStrobe = strobe;
  endtask

  // Behavioural TCM: acknowledges after tcmLatency wait cycles and drives
  // junk data whenever it is not acknowledging.
  task automatic modelTcm();
    if (arb_tcm_rd || arb_tcm_wr) begin
      if (waitCnt >= tcmLatency) begin
        tcm_ack   = 1'b1;
        tcm_rdata = memModel(arb_tcm_addr);
      end else begin
        tcm_ack   = 1'b0;
        tcm_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
      waitCnt++;
    end else begin
      tcm_ack   = forceIdleAck;
      tcm_rdata = {$urandom, $urandom, $urandom, $urandom};
      waitCnt   = 0;
    end
  endtask

  // Requesters drop their request in the ack cycle, or replace it with the
  // next one when they still have work queued.
  task automatic modelRequesters();
    if (arb_stbuf_write_ack) begin
      if (writeRepeat > 0) begin
        writeRepeat--;
        writeIdx++;
        write_addr = 32'h100 + 32'(4 * writeIdx);
        write_data = 32'ha0000000 + 32'(writeIdx);
      end else begin
        write_req = 1'b0;
      end
    end
    if (arb_stbuf_read_ack) read_req = 1'b0;
    if (arb_fetch_ack) begin
      if (fetchRepeat > 0) fetchRepeat--;
      else fetch_req = 1'b0;
    end
  endtask

  // One bench cycle, evaluated mid-cycle on the falling edge.
  task automatic tick();
    @(negedge clk);
    observe();
    modelTcm();
    modelRequesters();
  endtask

  // Run until every queued grant and response has been seen and all
  // requests are down, then step past RESP so the arbiter is idle.
  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while ((grantQ.size() != 0 || respQ.size() != 0 || fetch_req || read_req || write_req)
           && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $display("[TB] FAIL timeout: got %0d grants and %0d responses outstanding, expected 0",
               grantQ.size(), respQ.size());
      grantQ.delete();
      respQ.delete();
      fetch_req   = 1'b0;
      read_req    = 1'b0;
      write_req   = 1'b0;
      writeRepeat = 0;
      fetchRepeat = 0;
    end
    tick();
  endtask

  // Apply one table vector from an idle arbiter: the strobe must rise one
  // cycle after the request. With wait states the requester payload is
  // scrambled after the grant, which must not disturb the latched access.
  task automatic applyStimulus(input vector_t v);
    grant_t g;
    tcmLatency = v.latency;
    g.rd   = v.expRd;
    g.wr   = v.expWr;
    g.addr = v.addr;
    g.size = v.expSize;
    g.data = v.expData;
    pushExpected(v.kind, g, v.expResp);
    if (v.kind == K_FETCH) begin
      fetch_addr = v.addr;
      fetch_req  = 1'b1;
    end else if (v.kind == K_READ) begin
      read_addr = v.addr;
      read_size = v.size;
      read_req  = 1'b1;
    end else begin
      write_addr = v.addr;
      write_size = v.size;
      write_data = v.wdata;
      write_req  = 1'b1;
    end
    tick();
    checkOutput("grantLatency", arb_tcm_rd | arb_tcm_wr, 1);
    if (v.latency > 0) begin
      fetch_addr = $urandom;
      read_addr  = $urandom;
      read_size  = 2'(v.size + 2'd1);
      write_addr = $urandom;
      write_data = $urandom;
      write_size = 2'(v.size + 2'd1);
    end
    waitDone(60);
  endtask

  // Main sequence.
  initial begin
    grant_t g;

    vectors[0] = '{K_FETCH, 32'h10,   2'd0, 32'h0, 0, 1'b1, 1'b0, 2'd0, 32'h0,
                   128'habbccdde_12574985_1000203f_abcdef12};
    vectors[1] = '{K_READ,  32'h20,   2'd1, 32'h0, 0, 1'b1, 1'b0, 2'd1, 32'h0,
                   128'h00000000_00000000_00000000_fedd1698};
    vectors[2] = '{K_WRITE, 32'h44,   2'd2, 32'h13579bdf, 1, 1'b0, 1'b1, 2'd2, 32'h13579bdf,
                   128'h0};
    vectors[3] = '{K_FETCH, 32'h200,  2'd3, 32'h0, 2, 1'b1, 1'b0, 2'd0, 32'h0,
                   128'h5a5a585a_fffffdff_00000201_00000200};
    vectors[4] = '{K_READ,  32'h1000, 2'd3, 32'h0, 5, 1'b1, 1'b0, 2'd3, 32'h0,
                   128'h00000000_00000000_00000000_00001000};
    vectors[5] = '{K_WRITE, 32'h0,    2'd0, 32'hffffffff, 0, 1'b0, 1'b1, 2'd0, 32'hffffffff,
                   128'h0};

    $display("[TB] reset check");
    tick();
    tick();
    checkOutput("resetRd", arb_tcm_rd, 0);
    checkOutput("resetWr", arb_tcm_wr, 0);
    checkOutput("resetFetchData", arb_fetch_data, 0);
    checkOutput("resetStbufData", arb_stbuf_data, 0);
    rst_n = 1'b1;
    tick();

    $display("[TB] single-request vectors");
    for (int i = 0; i < 6; i++) applyStimulus(vectors[i]);

    $display("[TB] simultaneous write, read and fetch");
    tcmLatency = 0;
    pushExpected(K_WRITE, modelGrant(K_WRITE, 32'h30, 2'd2, 32'hdeadbeef), 128'h0);
    pushExpected(K_READ, modelGrant(K_READ, 32'h20, 2'd1, 32'h0), memModel(32'h20));
    pushExpected(K_FETCH, modelGrant(K_FETCH, 32'h10, 2'd0, 32'h0), memModel(32'h10));
    write_addr = 32'h30;
    write_size = 2'd2;
    write_data = 32'hdeadbeef;
    write_req  = 1'b1;
    read_addr  = 32'h20;
    read_size  = 2'd1;
    read_req   = 1'b1;
    fetch_addr = 32'h10;
    fetch_req  = 1'b1;
    waitDone(60);

    $display("[TB] TCM ack pulses while idle");
    forceIdleAck = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("idleAckNoStrobe", arb_tcm_rd | arb_tcm_wr, 0);
    end
    forceIdleAck = 1'b0;
    tick();
    tick();

    $display("[TB] fetch starvation against back-to-back writes");
    tcmLatency  = 0;
    writeIdx    = 0;
    writeRepeat = 7;
    fetchRepeat = 1;
    for (int round = 0; round < 2; round++) begin
      for (int w = 0; w < SL; w++) begin
        g = modelGrant(K_WRITE, 32'h100 + 32'(4 * (round * SL + w)), 2'd2,
                       32'ha0000000 + 32'(round * SL + w));
        pushExpected(K_WRITE, g, 128'h0);
      end
      pushExpected(K_FETCH, modelGrant(K_FETCH, 32'h300, 2'd0, 32'h0), memModel(32'h300));
    end
    write_addr = 32'h100;
    write_size = 2'd2;
    write_data = 32'ha0000000;
    write_req  = 1'b1;
    fetch_addr = 32'h300;
    fetch_req  = 1'b1;
    waitDone(200);

    $display("[TB] reset during a busy write");
    tcmLatency = 20;
    grantQ.push_back(modelGrant(K_WRITE, 32'h30, 2'd2, 32'hdeadbeef));
    write_addr = 32'h30;
    write_size = 2'd2;
    write_data = 32'hdeadbeef;
    write_req  = 1'b1;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abortWr", arb_tcm_wr, 0);
    checkOutput("abortRd", arb_tcm_rd, 0);
    checkOutput("abortAddr", arb_tcm_addr, 0);
    checkOutput("abortSize", arb_tcm_size, 0);
    checkOutput("abortData", arb_tcm_data, 0);
    checkOutput("abortAcks", {arb_fetch_ack, arb_stbuf_read_ack, arb_stbuf_write_ack}, 0);
    checkOutput("abortFetchData", arb_fetch_data, 0);
    checkOutput("abortStbufData", arb_stbuf_data, 0);
    write_req    = 1'b0;
    grantQ.delete();
    respQ.delete();
    prevStrobe   = 1'b0;
    expFetchData = '0;
    expStbufData = '0;
    tcmLatency   = 0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("postResetIdle", arb_tcm_rd | arb_tcm_wr, 0);
    end

    $display("[TB] fetch after reset");
    pushExpected(K_FETCH, modelGrant(K_FETCH, 32'h10, 2'd0, 32'h0), memModel(32'h10));
    fetch_addr = 32'h10;
    fetch_req  = 1'b1;
    waitDone(30);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
